// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op and state encodings,
// iteration count and the quotient returned for a zero divisor.
package mdu_pkg;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_FIN  = 2'b10
    } state_e;

    localparam int          ITER_COUNT    = 32;
    localparam int          CNT_W         = $clog2(ITER_COUNT);
    localparam logic [31:0] DIV0_QUOTIENT = 32'hFFFF_FFFF;

    function automatic logic op_is_div(input op_e o);
        return (o == OP_DIV) || (o == OP_DIVU);
    endfunction

    function automatic logic op_is_signed(input op_e o);
        return (o == OP_MULT) || (o == OP_DIV);
    endfunction

endpackage

// File: rtl/sign_fix.sv
// Conditional two's-complement negation, used both to take operand magnitudes
// and to restore the sign of results.
module sign_fix #(
    parameter int W = 32
) (
    input  logic [W-1:0] in_i,
    input  logic         cond_i,
    output logic [W-1:0] out_o
);

    assign out_o = cond_i ? (~in_i + W'(1)) : in_i;

endmodule

// File: rtl/mult_div_unit.sv
// Iterative 32x32 multiply / 32/32 divide unit with HI/LO result registers.
// One bit per cycle on magnitudes; the sign is restored in the final state.
module mult_div_unit
    import mdu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] rdat1,
    input  logic [31:0] rdat2,
    input  logic        mthi,
    input  logic        mtlo,
    input  logic [31:0] wdat,
    output logic        busy,
    output logic        done,
    output logic        div_zero,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    op_e              op_q, op_d;
    // Multiply: {partial product, multiplier}. Divide: {remainder, dividend -> quotient}.
    logic [63:0]      acc_q, acc_d;
    logic [31:0]      opb_q, opb_d;
    logic [31:0]      dividend_q, dividend_d;
    logic             neg_q, neg_d;
    logic             rem_neg_q, rem_neg_d;
    logic             div0_q, div0_d;
    logic [31:0]      hi_q, hi_d;
    logic [31:0]      lo_q, lo_d;
    logic             done_q, done_d;
    logic             div_zero_q, div_zero_d;

    op_e  op_in;
    logic in_signed;
    logic in_div;

    assign op_in     = op_e'(op);
    assign in_signed = op_is_signed(op_in);
    assign in_div    = op_is_div(op_in);

    logic [31:0] opnd_raw [2];
    logic [31:0] opnd_abs [2];

    assign opnd_raw[0] = rdat1;
    assign opnd_raw[1] = rdat2;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_abs
            sign_fix #(.W(32)) u_abs (
                .in_i   (opnd_raw[gi]),
                .cond_i (in_signed & opnd_raw[gi][31]),
                .out_o  (opnd_abs[gi])
            );
        end
    endgenerate

    logic [32:0] mul_sum;
    logic [63:0] mul_next;
    logic [32:0] div_shift;
    logic        div_ge;
    logic [31:0] div_diff;
    logic [63:0] div_next;

    assign mul_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opb_q} : 33'd0);
    assign mul_next = {mul_sum, acc_q[31:1]};

    // Remainder shifted left with the next dividend bit; the difference fits
    // in 32 bits whenever the subtraction is taken.
    assign div_shift = acc_q[63:31];
    assign div_ge    = div_shift >= {1'b0, opb_q};
    assign div_diff  = div_shift[31:0] - opb_q;
    assign div_next  = div_ge ? {div_diff, acc_q[30:0], 1'b1}
                              : {div_shift[31:0], acc_q[30:0], 1'b0};

    logic [63:0] prod_fix;
    logic [31:0] quot_fix;
    logic [31:0] rem_fix;

    sign_fix #(.W(64)) u_fix_prod (.in_i(acc_q),         .cond_i(neg_q),     .out_o(prod_fix));
    sign_fix #(.W(32)) u_fix_quot (.in_i(acc_q[31:0]),   .cond_i(neg_q),     .out_o(quot_fix));
    sign_fix #(.W(32)) u_fix_rem  (.in_i(acc_q[63:32]),  .cond_i(rem_neg_q), .out_o(rem_fix));

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        op_d       = op_q;
        acc_d      = acc_q;
        opb_d      = opb_q;
        dividend_d = dividend_q;
        neg_d      = neg_q;
        rem_neg_d  = rem_neg_q;
        div0_d     = div0_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        done_d     = 1'b0;
        div_zero_d = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d    = ST_RUN;
                    cnt_d      = '0;
                    op_d       = op_in;
                    acc_d      = {32'd0, in_div ? opnd_abs[0] : opnd_abs[1]};
                    opb_d      = in_div ? opnd_abs[1] : opnd_abs[0];
                    dividend_d = rdat1;
                    neg_d      = in_signed & (rdat1[31] ^ rdat2[31]);
                    rem_neg_d  = in_signed & rdat1[31];
                    div0_d     = in_div & (rdat2 == 32'd0);
                end else begin
                    if (mthi) hi_d = wdat;
                    if (mtlo) lo_d = wdat;
                end
            end
            ST_RUN: begin
                acc_d = op_is_div(op_q) ? div_next : mul_next;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(ITER_COUNT - 1)) state_d = ST_FIN;
            end
            ST_FIN: begin
                if (!op_is_div(op_q)) begin
                    {hi_d, lo_d} = prod_fix;
                end else if (div0_q) begin
                    hi_d = dividend_q;
                    lo_d = DIV0_QUOTIENT;
                end else begin
                    hi_d = rem_fix;
                    lo_d = quot_fix;
                end
                done_d     = 1'b1;
                div_zero_d = div0_q;
                state_d    = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            op_q       <= OP_MULT;
            acc_q      <= '0;
            opb_q      <= '0;
            dividend_q <= '0;
            neg_q      <= 1'b0;
            rem_neg_q  <= 1'b0;
            div0_q     <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            op_q       <= op_d;
            acc_q      <= acc_d;
            opb_q      <= opb_d;
            dividend_q <= dividend_d;
            neg_q      <= neg_d;
            rem_neg_q  <= rem_neg_d;
            div0_q     <= div0_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            done_q     <= done_d;
            div_zero_q <= div_zero_d;
        end
    end

    assign busy     = (state_q != ST_IDLE);
    assign done     = done_q;
    assign div_zero = div_zero_q;
    assign hi       = hi_q;
    assign lo       = lo_q;

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 Port list:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  launch request.
- op  in  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- rdat1  in  32  rs operand from register file: multiplicand or dividend.
- rdat2  in  32  rt operand from register file: multiplier or divisor.
- mthi  in  1  write HI from wdat.
- mtlo  in  1  write LO from wdat.
- wdat  in  32  move-to data.
- busy  out  1  operation in progress.
- done  out  1  one-cycle completion pulse.
- div_zero  out  1  divisor was zero; valid with done.
- hi  out  32  HI register.
- lo  out  32  LO register.

Function
REQ-003 The block SHALL have states IDLE, RUN and FIN.
REQ-004 In IDLE, start=1 SHALL be accepted in cycle T; the block SHALL then latch rdat1, rdat2 and op, and enter RUN at T+1.
REQ-005 RUN SHALL last exactly 32 cycles, T+1 to T+32, with a 5-bit iteration counter processing one bit per cycle:
- multiply: shift-add;
- divide: restoring shift-subtract.
REQ-006 FIN at T+33 SHALL apply the sign fix, register the result into hi/lo, and return to IDLE.
REQ-007 done SHALL be 1 in cycle T+34 only, with hi/lo already showing the new result; latency SHALL be 34 cycles for every op.
REQ-008 busy SHALL be 1 in cycles T+1 to T+33 and 0 otherwise.
REQ-009 Signed ops SHALL run the core on absolute values:
- product sign = sign(rdat1) XOR sign(rdat2);
- quotient sign = sign(rdat1) XOR sign(rdat2);
- remainder sign = sign(rdat1).
REQ-010 Results SHALL be stored as follows:
- MULT/MULTU: {hi, lo} = full 64-bit product;
- DIV/DIVU: lo = quotient, hi = remainder.
REQ-011 When the divisor is 0, the block SHALL take the same 34-cycle latency and SHALL produce lo=0xFFFFFFFF, hi=dividend as given, and div_zero=1 in the done cycle; div_zero SHALL be 0 in all other cycles.
REQ-012 Signed 0x80000000 / 0xFFFFFFFF SHALL yield lo=0x80000000, hi=0 with no trap.
REQ-013 start while busy=1 SHALL be ignored.
REQ-014 start in the done cycle (T+34) SHALL be accepted.
REQ-015 mthi/mtlo SHALL write wdat at the clock edge only when busy=0 and start=0; otherwise they SHALL be ignored.
REQ-016 If start, mthi and mtlo are asserted together in IDLE, start SHALL win.
REQ-017 mthi and mtlo asserted together SHALL write both registers.
REQ-018 hi/lo SHALL hold their value while busy; they SHALL change only in FIN or on a move-to write.

Reset
REQ-019 rst=1 at a clock edge SHALL force:
- state = IDLE, counter = 0;
- busy = 0, done = 0, div_zero = 0;
- hi = 0, lo = 0.
REQ-020 Reset during RUN or FIN SHALL abort the operation: no done pulse and no partial result on hi/lo.
REQ-021 rst SHALL have priority over start, mthi and mtlo.

Structure
REQ-022 A shared package mdu_pkg SHALL hold:
- the op encodings;
- the state encoding;
- ITER_COUNT = 32;
- DIV0_QUOTIENT = 0xFFFFFFFF.
REQ-023 Two's-complement conditional negation SHALL be a sub-module, sign_fix (in 32/64-bit parameterised width, cond, out), reused for operand absolute values and result correction.
REQ-024 The block SHALL be a single clock domain with no combinational path from inputs to outputs.

Verification
REQ-025 MULT rdat1=0xFFFFFFFE, rdat2=0x00000003 at T SHALL give done at T+34 with hi=0xFFFFFFFF, lo=0xFFFFFFFA; busy SHALL be high T+1 to T+33.
REQ-026 MULTU 0xFFFFFFFF × 0xFFFFFFFF SHALL give hi=0xFFFFFFFE, lo=0x00000001.
REQ-027 Divide results:
- DIV 0xFFFFFFF9 / 0x00000002 SHALL give lo=0xFFFFFFFD, hi=0xFFFFFFFF;
- DIVU 7 / 2 SHALL give lo=3, hi=1.
REQ-028 Divide boundary cases:
- DIV 0x00001234 / 0 SHALL give lo=0xFFFFFFFF, hi=0x00001234, div_zero=1 together with done;
- DIV 0x80000000 / 0xFFFFFFFF SHALL give lo=0x80000000, hi=0.
REQ-029 Protocol and reset:
- start re-pulsed at T+5 SHALL be ignored, with one done at T+34;
- mthi with wdat=0xA5A5A5A5 at T+10 SHALL be ignored;
- rst at T+12 SHALL give busy=0 at T+13, no done, and hi=lo=0.
REQ-030 Back-to-back and move-to:
- a second start in the done cycle SHALL complete 34 cycles later;
- in IDLE, mtlo wdat=0x12345678 SHALL give lo=0x12345678 the next cycle with hi unchanged.
